// File: rtl/interrupt_ctrl_if.sv
// rtl/interrupt_ctrl_if.sv - source/mask/ack/eoi and status bundle between interrupt sources, PicoBlaze and controller
interface interrupt_ctrl_if #(
   parameter int NUM_SRC = 4,
   parameter int VEC_W   = 2
);
   logic [NUM_SRC-1:0] src_in;
   logic [NUM_SRC-1:0] mask_in;
   logic               interrupt_ack;
   logic               eoi;
   logic               ovf_clr;
   logic               interrupt;
   logic [VEC_W-1:0]   vector;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] overflow;
   logic               in_service;
   logic               timeout_err;

   modport master (
      output src_in, mask_in, interrupt_ack, eoi, ovf_clr,
      input  interrupt, vector, pending, overflow, in_service, timeout_err
   );

   modport slave (
      input  src_in, mask_in, interrupt_ack, eoi, ovf_clr,
      output interrupt, vector, pending, overflow, in_service, timeout_err
   );
endinterface

// File: rtl/interrupt_ctrl.sv
// rtl/interrupt_ctrl.sv - fixed-priority edge-latched interrupt controller for PicoBlaze
// Optional ack watchdog enabled by defining INTC_ACK_TIMEOUT_EN.
module interrupt_ctrl #(
   parameter int NUM_SRC     = 4,
   parameter int VEC_W       = 2,
   parameter int ACK_TIMEOUT = 1000
) (
   input logic            clk,
   input logic            reset_n,
   interrupt_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t             state;
   state_t             state_nx;
   logic [NUM_SRC-1:0] src_d;
   logic [NUM_SRC-1:0] pending_q;
   logic [NUM_SRC-1:0] overflow_q;
   logic [NUM_SRC-1:0] edge_det;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] clr_mask;
   logic [NUM_SRC-1:0] ovf_set;
   logic [VEC_W-1:0]   winner;
   logic [VEC_W-1:0]   vector_q;
   logic               interrupt_q;
   logic               interrupt_nx;
   logic               capture;
   logic               timeout_hit;

   generate
      if (NUM_SRC < 1 || NUM_SRC > 16 || NUM_SRC > (2 ** VEC_W) || ACK_TIMEOUT < 1) begin : g_bad_param
         $error("interrupt_ctrl: illegal NUM_SRC/VEC_W/ACK_TIMEOUT combination");
      end
   endgenerate

   assign edge_det = bus.src_in & ~src_d;
   assign eligible = pending_q & bus.mask_in;

   // Scan from the top down so the lowest eligible index is the last one written.
   always_comb begin
      winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner = VEC_W'(i);
      end
   end

   always_comb begin
      state_nx     = state;
      interrupt_nx = interrupt_q;
      capture      = 1'b0;
      case (state)
         IDLE: begin
            if (|eligible) begin
               state_nx     = REQ;
               interrupt_nx = 1'b1;
            end
         end
         REQ: begin
            if (bus.interrupt_ack && (|eligible)) begin
               state_nx     = SERVICE;
               interrupt_nx = 1'b0;
               capture      = 1'b1;
            end else if (!(|eligible) || timeout_hit) begin
               state_nx     = IDLE;
               interrupt_nx = 1'b0;
            end
         end
         SERVICE: begin
            if (bus.eoi) state_nx = IDLE;
         end
         default: begin
            state_nx     = IDLE;
            interrupt_nx = 1'b0;
         end
      endcase
   end

   always_comb begin
      clr_mask = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         clr_mask[i] = capture && (winner == VEC_W'(i));
      end
   end

   // A fresh edge on the bit being cleared re-pends it without counting as overflow.
   assign ovf_set = edge_det & pending_q & ~clr_mask;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_d       <= '0;
         pending_q   <= '0;
         overflow_q  <= '0;
         vector_q    <= '0;
         interrupt_q <= 1'b0;
      end else begin
         src_d       <= bus.src_in;
         pending_q   <= (pending_q & ~clr_mask) | edge_det;
         overflow_q  <= (bus.ovf_clr ? '0 : overflow_q) | ovf_set;
         interrupt_q <= interrupt_nx;
         if (capture) vector_q <= winner;
      end
   end

`ifdef INTC_ACK_TIMEOUT_EN
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   logic [CNT_W-1:0] ack_cnt;
   logic             timeout_q;
   logic             timed_out;

   assign timeout_hit = (state == REQ) && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));
   assign timed_out   = timeout_hit && (|eligible) && !bus.interrupt_ack;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_cnt   <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == IDLE && state_nx == REQ) ack_cnt <= '0;
         else if (state == REQ)                ack_cnt <= ack_cnt + CNT_W'(1);
         timeout_q <= (bus.ovf_clr ? 1'b0 : timeout_q) | timed_out;
      end
   end

   assign bus.timeout_err = timeout_q;
`else
   assign timeout_hit     = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   assign bus.interrupt  = interrupt_q;
   assign bus.vector     = vector_q;
   assign bus.pending    = pending_q;
   assign bus.overflow   = overflow_q;
   assign bus.in_service = (state == SERVICE);
endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb/tb_interrupt_ctrl.sv - directed self-checking bench for interrupt_ctrl
module tb_interrupt_ctrl;
   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   interrupt_ctrl_if #(.NUM_SRC(4), .VEC_W(2)) bus ();

   interrupt_ctrl #(.NUM_SRC(4), .VEC_W(2), .ACK_TIMEOUT(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n           = 1'b0;
      bus.src_in        = 4'b0000;
      bus.mask_in       = 4'b1111;
      bus.interrupt_ack = 1'b0;
      bus.eoi           = 1'b0;
      bus.ovf_clr       = 1'b0;
      repeat (3) step();
      check("rst_interrupt", 32'(bus.interrupt), 32'd0);
      check("rst_vector", 32'(bus.vector), 32'd0);
      check("rst_pending", 32'(bus.pending), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      check("rst_in_service", 32'(bus.in_service), 32'd0);
      check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
      reset_n = 1'b1;
      step();

      // single source
      bus.src_in = 4'b0100;
      step();
      check("single_pending", 32'(bus.pending), 32'h4);
      check("single_int_e0", 32'(bus.interrupt), 32'd0);
      bus.src_in = 4'b0000;
      step();
      check("single_int_e1", 32'(bus.interrupt), 32'd1);
      bus.interrupt_ack = 1'b1;
      step();
      bus.interrupt_ack = 1'b0;
      check("single_vector", 32'(bus.vector), 32'd2);
      check("single_pending_clr", 32'(bus.pending), 32'd0);
      check("single_in_service", 32'(bus.in_service), 32'd1);
      check("single_int_low", 32'(bus.interrupt), 32'd0);
      bus.eoi = 1'b1;
      step();
      bus.eoi = 1'b0;
      check("single_eoi_idle", 32'(bus.in_service), 32'd0);
      step();
      check("single_no_reint", 32'(bus.interrupt), 32'd0);

      // priority
      bus.src_in = 4'b1010;
      step();
      bus.src_in = 4'b0000;
      check("prio_pending", 32'(bus.pending), 32'ha);
      step();
      check("prio_int", 32'(bus.interrupt), 32'd1);
      bus.interrupt_ack = 1'b1;
      step();
      bus.interrupt_ack = 1'b0;
      check("prio_vector1", 32'(bus.vector), 32'd1);
      check("prio_pending_left", 32'(bus.pending), 32'h8);
      bus.eoi = 1'b1;
      step();
      bus.eoi = 1'b0;
      check("prio_idle_gap", 32'(bus.interrupt), 32'd0);
      step();
      check("prio_reassert", 32'(bus.interrupt), 32'd1);
      bus.interrupt_ack = 1'b1;
      step();
      bus.interrupt_ack = 1'b0;
      check("prio_vector3", 32'(bus.vector), 32'd3);
      check("prio_pending_empty", 32'(bus.pending), 32'd0);
      bus.eoi = 1'b1;
      step();
      bus.eoi = 1'b0;

      // mask
      bus.mask_in = 4'b0000;
      bus.src_in  = 4'b0001;
      step();
      bus.src_in = 4'b0000;
      check("mask_pending", 32'(bus.pending), 32'h1);
      step();
      step();
      check("mask_no_int", 32'(bus.interrupt), 32'd0);
      bus.mask_in = 4'b0001;
      step();
      check("mask_unmask_int", 32'(bus.interrupt), 32'd1);
      bus.mask_in = 4'b0000;
      step();
      check("mask_remask_drop", 32'(bus.interrupt), 32'd0);
      check("mask_pending_kept", 32'(bus.pending), 32'h1);
      bus.interrupt_ack = 1'b1;
      step();
      bus.interrupt_ack = 1'b0;
      check("mask_ack_ignored", 32'(bus.in_service), 32'd0);
      bus.mask_in = 4'b1111;
      step();
      bus.interrupt_ack = 1'b1;
      step();
      bus.interrupt_ack = 1'b0;
      check("mask_vector0", 32'(bus.vector), 32'd0);
      bus.eoi = 1'b1;
      step();
      bus.eoi = 1'b0;

      // overflow
      bus.src_in = 4'b0010;
      step();
      bus.src_in = 4'b0000;
      step();
      bus.src_in = 4'b0010;
      step();
      bus.src_in = 4'b0000;
      check("ovf_set", 32'(bus.overflow), 32'h2);
      step();
      check("ovf_req", 32'(bus.interrupt), 32'd1);
      bus.src_in        = 4'b0010;
      bus.interrupt_ack = 1'b1;
      step();
      bus.src_in        = 4'b0000;
      bus.interrupt_ack = 1'b0;
      check("ovf_ack_vector", 32'(bus.vector), 32'd1);
      check("ovf_set_wins_clr", 32'(bus.pending), 32'h2);
      check("ovf_unchanged", 32'(bus.overflow), 32'h2);
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      check("ovf_cleared", 32'(bus.overflow), 32'd0);
      bus.src_in  = 4'b0010;
      bus.ovf_clr = 1'b1;
      step();
      bus.src_in  = 4'b0000;
      bus.ovf_clr = 1'b0;
      check("ovf_set_beats_clr", 32'(bus.overflow), 32'h2);
      bus.interrupt_ack = 1'b1;
      step();
      bus.interrupt_ack = 1'b0;
      check("svc_ack_ignored_pend", 32'(bus.pending), 32'h2);
      check("svc_ack_ignored_state", 32'(bus.in_service), 32'd1);

      // asynchronous reset mid-SERVICE
      #2 reset_n = 1'b0;
      #1;
      check("arst_interrupt", 32'(bus.interrupt), 32'd0);
      check("arst_vector", 32'(bus.vector), 32'd0);
      check("arst_pending", 32'(bus.pending), 32'd0);
      check("arst_overflow", 32'(bus.overflow), 32'd0);
      check("arst_in_service", 32'(bus.in_service), 32'd0);
      bus.src_in = 4'b0001;
      step();
      reset_n = 1'b1;
      step();
      check("held_src_edge", 32'(bus.pending), 32'h1);
      step();
      check("held_src_int", 32'(bus.interrupt), 32'd1);

`ifdef INTC_ACK_TIMEOUT_EN
      for (int i = 0; i < 7; i++) begin
         step();
         check("to_int_held", 32'(bus.interrupt), 32'd1);
      end
      step();
      check("to_int_drop", 32'(bus.interrupt), 32'd0);
      check("to_err_set", 32'(bus.timeout_err), 32'd1);
      check("to_pending_kept", 32'(bus.pending), 32'h1);
      step();
      check("to_rearm", 32'(bus.interrupt), 32'd1);
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      check("to_err_clr", 32'(bus.timeout_err), 32'd0);
`else
      for (int i = 0; i < 100; i++) begin
         step();
         check("hold_int", 32'(bus.interrupt), 32'd1);
      end
      check("hold_no_timeout_err", 32'(bus.timeout_err), 32'd0);
`endif
      bus.interrupt_ack = 1'b1;
      step();
      bus.interrupt_ack = 1'b0;
      check("final_vector", 32'(bus.vector), 32'd0);
      check("final_pending", 32'(bus.pending), 32'd0);
      bus.eoi = 1'b1;
      step();
      bus.eoi = 1'b0;
      check("final_idle", 32'(bus.in_service), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Prioritised interrupt controller sitting between the design's interrupt sources (1 s heartbeat tick, UART, capture-done, trigger) and the PicoBlaze `interrupt`/`interrupt_ack` pins. It edge-detects up to NUM_SRC source lines, latches them as pending, applies a mask, and presents one interrupt at a time to the processor. It records the winning vector on acknowledge and blocks further interrupts until the ISR signals end-of-interrupt.

## Interface
- NUM_SRC, 4, number of interrupt source lines (1..16)
- VEC_W, 2, vector width; NUM_SRC <= 2**VEC_W required
- ACK_TIMEOUT, 1000, cycles allowed between raising `interrupt` and `interrupt_ack`; used only with INTC_ACK_TIMEOUT_EN
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- src_in  in  NUM_SRC  source lines, synchronous to clk, level; rising edge = request
- mask_in  in  NUM_SRC  1 = source enabled
- interrupt_ack  in  1  PicoBlaze acknowledge, one-cycle pulse
- eoi  in  1  end-of-interrupt strobe from ISR, one-cycle pulse
- ovf_clr  in  1  clears all overflow bits
- interrupt  out  1  registered interrupt request to PicoBlaze
- vector  out  VEC_W  index of source being serviced
- pending  out  NUM_SRC  latched pending bits
- overflow  out  NUM_SRC  sticky: edge arrived while that bit was already pending
- in_service  out  1  high while in SERVICE
- timeout_err  out  1  sticky ack-timeout flag (macro only)

## Operation
- Edge detect: `src_d` registers src_in; edge[i] = src_in[i] & ~src_d[i].
- Pending: set on edge[i]; cleared only for the vector captured on ack. Set and clear in the same cycle on the same bit: set wins, no overflow.
- Overflow[i] set when edge[i] and pending[i] already 1 and not being cleared that cycle; ovf_clr clears all; ovf_clr with a simultaneous new overflow: set wins.
- Eligible = pending & mask_in. Winner = lowest eligible index (fixed priority, index 0 highest).
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if eligible != 0 -> REQ, interrupt <= 1.
  - REQ: interrupt_ack -> SERVICE, interrupt <= 0, vector <= current winner, clear pending[winner]. Else if eligible == 0 (masked/none) -> IDLE, interrupt <= 0. Ack wins over simultaneous loss of eligibility only if eligible != 0 that cycle; ack with eligible == 0 -> IDLE, nothing cleared.
  - SERVICE: in_service = 1; edges still latch; eoi -> IDLE.
- interrupt_ack outside REQ and eoi outside SERVICE are ignored.
- Winner is re-evaluated every REQ cycle; a higher-priority arrival before ack changes vector captured.

## Timing
- Reset (async assert): src_d=0, pending=0, overflow=0, vector=0, interrupt=0, in_service=0, timeout_err=0, state IDLE, timeout counter 0. src_d resets to 0, so a source held high through reset release registers one edge on the first clock.
- src_in rising before edge E0 -> pending set at E0 -> interrupt high after E1 (2-cycle latency).
- Ack sampled at edge Ea -> interrupt low, vector valid, in_service high after Ea.
- eoi at edge Ee -> IDLE after Ee; if eligible remains, interrupt high after Ee+1 (one idle cycle minimum between interrupts).
- Reset mid-operation: all state discarded immediately, including pending.

## Configuration
- INTC_ACK_TIMEOUT_EN defined: counter runs in REQ, cleared on entering REQ; on reaching ACK_TIMEOUT cycles without ack -> IDLE, interrupt <= 0, timeout_err <= 1 (sticky, cleared by ovf_clr or reset), pending untouched so the request re-arms next cycle.
- Not defined: no counter, timeout_err tied 0, REQ waits indefinitely.

## Test plan
- Single source: pulse src_in[2] with mask 4'b1111 -> interrupt high 2 cycles later; ack -> vector=2, pending=0, in_service=1; eoi -> IDLE, interrupt stays 0.
- Priority: edges on src 3 and 1 same cycle -> ack gives vector=1, pending=4'b1000; eoi -> interrupt re-asserts one cycle later, second ack gives vector=3.
- Mask: pending[0] set, mask_in=0 -> interrupt never asserts; unmask in REQ path -> asserts; remask before ack -> interrupt drops, pending[0] stays 1.
- Overflow: two edges on src 1 before ack -> overflow=4'b0010; edge coincident with ack clearing pending[1] -> pending[1]=1, overflow unchanged; ovf_clr -> overflow=0.
- Reset mid-SERVICE: assert reset_n low asynchronously -> all outputs 0 before next clock edge.
- With INTC_ACK_TIMEOUT_EN, ACK_TIMEOUT=8: no ack -> interrupt drops after 8 cycles, timeout_err=1, interrupt re-asserts; without macro, interrupt held 100 cycles, timeout_err=0.
